cv32e40px_x_result_arb: RTL and testbench
=========================================

CV32E40PX_X_RESULT_ARB -- requirements
Module: cv32e40px_x_result_arb

Interface
REQ-001 Parameter NUM_COPROC, default 2, is the number of coprocessor result channels; legal range is 2..8.
REQ-002 Parameter X_ID_WIDTH, default 4, is the instruction ID width.
REQ-003 Port clk_i, input, 1 bit, is the single clock; all state is updated on its rising edge.
REQ-004 Port rst_ni, input, 1 bit, is the reset: asynchronous and active-low.
REQ-005 Port cp_result_valid_i, input, NUM_COPROC bits, is the per-coprocessor result valid.
REQ-006 Port cp_result_ready_o, output, NUM_COPROC bits, is the per-coprocessor result ready.
REQ-007 Port cp_result_id_i, input, NUM_COPROC x X_ID_WIDTH bits, is the per-coprocessor instruction ID.
REQ-008 Port cp_result_data_i, input, NUM_COPROC x 32 bits, is the per-coprocessor writeback data.
REQ-009 Port cp_result_rd_i, input, NUM_COPROC x 5 bits, is the per-coprocessor destination register.
REQ-010 Port cp_result_we_i, input, NUM_COPROC bits, is the per-coprocessor write enable.
REQ-011 Port x_result_valid_o, input/output pair with x_result_ready_i (input, 1 bit), forms the merged core-side result handshake; x_result_valid_o is the output, 1 bit.
REQ-012 Ports x_result_id_o (X_ID_WIDTH), x_result_data_o (32), x_result_rd_o (5) and x_result_we_o (1) are outputs carrying the merged core-side result payload.
REQ-013 Port grant_idx_o, output, $clog2(NUM_COPROC) bits, is the index of the source of the result currently held in the output register.

Function
REQ-014 The block SHALL contain a one-entry output register: out_valid_q plus the payload and source index.
REQ-015 Load enable is load_en = (~out_valid_q | x_result_ready_i) & (|cp_result_valid_i).
REQ-016 The winner SHALL be the first asserted cp_result_valid_i[i], searching upward from rr_ptr_q and wrapping from NUM_COPROC-1 to 0.
REQ-017 cp_result_ready_o[i] SHALL be load_en & (winner == i); at most one bit is high per cycle, and it is combinational with respect to valid.
REQ-018 On load_en, the output register SHALL capture the winner payload, and rr_ptr_q SHALL be set to (winner+1) mod NUM_COPROC.
REQ-019 On load_en, x_result_we_o SHALL be captured as cp_result_we_i[winner] & (cp_result_rd_i[winner] != 0).
REQ-020 When out_valid_q & x_result_ready_i & ~(|cp_result_valid_i), out_valid_q SHALL clear on the next edge.
REQ-021 Latency is exactly 1 cycle from a coprocessor handshake to x_result_valid_o.
REQ-022 Sustained throughput is 1 result per cycle while x_result_ready_i=1.
REQ-023 While x_result_valid_o=1 and x_result_ready_i=0:
  - the payload and grant_idx_o SHALL remain stable;
  - all cp_result_ready_o SHALL be 0;
  - rr_ptr_q SHALL be unchanged.
REQ-024 A requester not granted SHALL be held (ready low) until granted; with all inputs continuously valid, every requester SHALL be granted within NUM_COPROC loads.
REQ-025 A requester that deasserts valid before its grant SHALL not advance rr_ptr_q.
REQ-026 In the same cycle, output drain and new load SHALL both occur (back-to-back), with no bubble.

Reset
REQ-027 On rst_ni=0, asynchronously:
  - out_valid_q = 0, so x_result_valid_o = 0;
  - rr_ptr_q = 0 and grant_idx_o = 0;
  - x_result_id_o, x_result_data_o and x_result_rd_o = 0, and x_result_we_o = 0;
  - cp_result_ready_o = 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held result, and no ready SHALL be issued during reset.

Structure
REQ-029 X_ID_WIDTH and a packed x_result_t struct (id, data, rd, we) SHALL reside in cv32e40px_core_v_xif_pkg.
REQ-030 The wrapping priority search SHALL be a sub-module, cv32e40px_x_rr_pick, with inputs req vector and pointer and outputs winner index and any_valid.
REQ-031 All flops SHALL reside in cv32e40px_x_result_arb; cv32e40px_x_rr_pick SHALL be purely combinational.

Verification
REQ-032 Single source: cp0 valid with id=3, data=0xDEADBEEF, rd=5, we=1 at cycle 0 -> cp_result_ready_o=01 at cycle 0; x_result_valid_o=1, id=3, data=0xDEADBEEF, rd=5, we=1, grant_idx_o=0 at cycle 1.
REQ-033 Contention, NUM_COPROC=2: both valid from cycle 0 with ready_i=1 -> grants cp0, cp1, cp0, cp1, ... on consecutive cycles; rr_ptr_q toggles each cycle.
REQ-034 Backpressure: output loaded from cp1, then ready_i=0 for 3 cycles -> payload and grant_idx_o=1 stable, cp_result_ready_o=00 throughout; ready_i=1 at cycle 4 -> next pending result appears at cycle 5.
REQ-035 rd=0: cp1 sends rd=0, we=1 -> x_result_we_o=0, with valid and id still forwarded.
REQ-036 Wrap, NUM_COPROC=4: rr_ptr_q=3, valid=0101 -> winner 0, rr_ptr_q becomes 1; next cycle, valid=0100 -> winner 2.
REQ-037 Reset: rst_ni driven low asynchronously while out_valid_q=1 -> x_result_valid_o=0 immediately, before the next clock edge; after release with no inputs valid, outputs stay 0.

Source files
------------

// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared eXtension-interface types for the coprocessor result path.
package cv32e40px_core_v_xif_pkg;

   localparam int unsigned X_ID_WIDTH = 4;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [31:0]           data;
      logic [4:0]            rd;
      logic                  we;
   } x_result_t;

endpackage

// File: rtl/cv32e40px_x_rr_pick.sv
// Wrapping priority search: first set request at or above ptr_i, wrapping to 0.
module cv32e40px_x_rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic [$clog2(NUM_REQ)-1:0] winner_o,
   output logic                       any_valid_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   assign any_valid_o = |req_i;

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      winner_o = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (req_i[(int'(ptr_i) + off) % NUM_REQ]) begin
            winner_o = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/cv32e40px_x_result_arb.sv
// Round-robin merge of coprocessor result channels into a single registered
// core-side result handshake.
module cv32e40px_x_result_arb
   import cv32e40px_core_v_xif_pkg::*;
#(
   parameter int NUM_COPROC = 2,
   parameter int X_ID_WIDTH = cv32e40px_core_v_xif_pkg::X_ID_WIDTH
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NUM_COPROC-1:0]                 cp_result_valid_i,
   output logic [NUM_COPROC-1:0]                 cp_result_ready_o,
   input  logic [NUM_COPROC-1:0][X_ID_WIDTH-1:0] cp_result_id_i,
   input  logic [NUM_COPROC-1:0][31:0]           cp_result_data_i,
   input  logic [NUM_COPROC-1:0][4:0]            cp_result_rd_i,
   input  logic [NUM_COPROC-1:0]                 cp_result_we_i,
   output logic                                  x_result_valid_o,
   input  logic                                  x_result_ready_i,
   output logic [X_ID_WIDTH-1:0]                 x_result_id_o,
   output logic [31:0]                           x_result_data_o,
   output logic [4:0]                            x_result_rd_o,
   output logic                                  x_result_we_o,
   output logic [$clog2(NUM_COPROC)-1:0]         grant_idx_o
);

   localparam int IDX_W = $clog2(NUM_COPROC);

   logic             out_valid_q, out_valid_d;
   x_result_t        res_q, res_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] winner;
   logic             any_valid;
   logic             load_en;

   cv32e40px_x_rr_pick #(
      .NUM_REQ (NUM_COPROC)
   ) u_pick (
      .req_i       (cp_result_valid_i),
      .ptr_i       (rr_ptr_q),
      .winner_o    (winner),
      .any_valid_o (any_valid)
   );

   assign load_en = (~out_valid_q | x_result_ready_i) & any_valid;

   // Gated by reset so no source sees a handshake while the block is held.
   always_comb begin
      cp_result_ready_o = '0;
      if (load_en && rst_ni) begin
         cp_result_ready_o[winner] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         out_valid_d = 1'b1;
         res_d.id    = cp_result_id_i[winner];
         res_d.data  = cp_result_data_i[winner];
         res_d.rd    = cp_result_rd_i[winner];
         res_d.we    = cp_result_we_i[winner] & (cp_result_rd_i[winner] != 5'd0);
         grant_d     = winner;
         rr_ptr_d    = (winner == IDX_W'(NUM_COPROC - 1)) ? '0 : winner + 1'b1;
      end else if (x_result_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign x_result_valid_o = out_valid_q;
   assign x_result_id_o    = res_q.id;
   assign x_result_data_o  = res_q.data;
   assign x_result_rd_o    = res_q.rd;
   assign x_result_we_o    = res_q.we;
   assign grant_idx_o      = grant_q;

endmodule

// File: tb/tb_cv32e40px_x_result_arb.sv
// Scoreboard bench for the result arbiter, with a 2-channel and a 4-channel instance.
module tb_cv32e40px_x_result_arb;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      int          idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]       v = '0;
   logic [3:0][3:0]  id_v = '0;
   logic [3:0][31:0] data_v = '0;
   logic [3:0][4:0]  rd_v = '0;
   logic [3:0]       we_v = '0;
   logic             rdy = 1'b0;
   logic             sel = 1'b0;   // 0: drive the 2-channel DUT, 1: the 4-channel DUT

   logic [1:0] v2;
   logic [3:0] v4;
   assign v2 = sel ? 2'b00 : v[1:0];
   assign v4 = sel ? v : 4'b0000;

   logic [1:0]  r2;
   logic        xv2, xwe2;
   logic [3:0]  xid2;
   logic [31:0] xd2;
   logic [4:0]  xrd2;
   logic [0:0]  g2;
   logic [3:0]  r4;
   logic        xv4, xwe4;
   logic [3:0]  xid4;
   logic [31:0] xd4;
   logic [4:0]  xrd4;
   logic [1:0]  g4;

   cv32e40px_x_result_arb #(.NUM_COPROC(2), .X_ID_WIDTH(4)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n),
      .cp_result_valid_i(v2), .cp_result_ready_o(r2),
      .cp_result_id_i(id_v[1:0]), .cp_result_data_i(data_v[1:0]),
      .cp_result_rd_i(rd_v[1:0]), .cp_result_we_i(we_v[1:0]),
      .x_result_valid_o(xv2), .x_result_ready_i(rdy),
      .x_result_id_o(xid2), .x_result_data_o(xd2), .x_result_rd_o(xrd2),
      .x_result_we_o(xwe2), .grant_idx_o(g2)
   );

   cv32e40px_x_result_arb #(.NUM_COPROC(4), .X_ID_WIDTH(4)) u_dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .cp_result_valid_i(v4), .cp_result_ready_o(r4),
      .cp_result_id_i(id_v), .cp_result_data_i(data_v),
      .cp_result_rd_i(rd_v), .cp_result_we_i(we_v),
      .x_result_valid_o(xv4), .x_result_ready_i(rdy),
      .x_result_id_o(xid4), .x_result_data_o(xd4), .x_result_rd_o(xrd4),
      .x_result_we_o(xwe4), .grant_idx_o(g4)
   );

   int tests = 0;
   int fails = 0;
   exp_t q[$];
   int m_ptr = 0;

   logic [3:0]  o_rdy;
   logic        o_xv, o_we;
   logic [3:0]  o_id;
   logic [31:0] o_data;
   logic [4:0]  o_rd;
   logic [1:0]  o_g;

   task automatic sample();
      if (!sel) begin
         o_rdy = {2'b00, r2}; o_xv = xv2; o_id = xid2; o_data = xd2;
         o_rd = xrd2; o_we = xwe2; o_g = {1'b0, g2};
      end else begin
         o_rdy = r4; o_xv = xv4; o_id = xid4; o_data = xd4;
         o_rd = xrd4; o_we = xwe4; o_g = g4;
      end
   endtask

   task automatic set_lane(input int i, input logic [3:0] id, input logic [31:0] d,
                           input logic [4:0] rd, input logic we);
      id_v[i] = id; data_v[i] = d; rd_v[i] = rd; we_v[i] = we;
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < 4; i++)
         set_lane(i, 4'($urandom), $urandom, 5'($urandom_range(0, 31)), 1'($urandom));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; v = '0; rdy = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_ptr = 0;
   endtask

   // One cycle: drive, check ready before the edge, update model at the edge, check outputs after.
   task automatic step(input logic [3:0] vv, input logic rr, input string name);
      int n, w;
      logic [3:0] act, exp_rdy;
      logic load, consumed;
      exp_t e;
      v = vv; rdy = rr;
      #1;
      n = sel ? 4 : 2;
      act = vv & (sel ? 4'hF : 4'h3);
      w = -1;
      for (int k = 0; k < n; k++) begin
         int j = (m_ptr + k) % n;
         if (w < 0 && act[j]) w = j;
      end
      load = (w >= 0) && (q.size() == 0 || rr);
      exp_rdy = load ? 4'(1 << w) : 4'b0000;
      consumed = (q.size() != 0) && rr;
      sample();
      tests++;
      if (o_rdy !== exp_rdy) begin
         fails++;
         $display("FAIL %s ready: got %b want %b", name, o_rdy, exp_rdy);
      end
      @(posedge clk);
      if (consumed) void'(q.pop_front());
      if (load) begin
         e.id = id_v[w]; e.data = data_v[w]; e.rd = rd_v[w];
         e.we = we_v[w] & (rd_v[w] != 5'd0); e.idx = w;
         q.push_back(e);
         m_ptr = (w + 1) % n;
      end
      #1;
      sample();
      tests++;
      if (q.size() != 0) begin
         if (o_xv !== 1'b1 || o_id !== q[0].id || o_data !== q[0].data ||
             o_rd !== q[0].rd || o_we !== q[0].we || o_g !== 2'(q[0].idx)) begin
            fails++;
            $display("FAIL %s out: got v=%b id=%h d=%h rd=%0d we=%b g=%0d want v=1 id=%h d=%h rd=%0d we=%b g=%0d",
                     name, o_xv, o_id, o_data, o_rd, o_we, o_g,
                     q[0].id, q[0].data, q[0].rd, q[0].we, q[0].idx);
         end
      end else if (o_xv !== 1'b0) begin
         fails++;
         $display("FAIL %s out: got valid=%b want 0", name, o_xv);
      end
   endtask

   task automatic test_reset();
      v = 4'hF; rdy = 1'b1;
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         sample();
         tests++;
         if (o_rdy !== 4'b0 || o_xv !== 1'b0 || o_id !== 4'h0 || o_data !== 32'h0 ||
             o_rd !== 5'h0 || o_we !== 1'b0 || o_g !== 2'b0) begin
            fails++;
            $display("FAIL reset_state sel=%0d: got rdy=%b v=%b id=%h d=%h rd=%0d we=%b g=%0d want all 0",
                     s, o_rdy, o_xv, o_id, o_data, o_rd, o_we, o_g);
         end
      end
      sel = 1'b0;
      do_reset();
   endtask

   task automatic test_single();
      sel = 1'b0; do_reset();
      set_lane(0, 4'h3, 32'hDEADBEEF, 5'd5, 1'b1);
      step(4'b0001, 1'b1, "single_load");
      tests++;
      if (o_xv !== 1'b1 || o_id !== 4'h3 || o_data !== 32'hDEADBEEF || o_rd !== 5'd5 ||
          o_we !== 1'b1 || o_g !== 2'd0) begin
         fails++;
         $display("FAIL single_const: got v=%b id=%h d=%h rd=%0d we=%b g=%0d want 1 3 deadbeef 5 1 0",
                  o_xv, o_id, o_data, o_rd, o_we, o_g);
      end
      step(4'b0000, 1'b1, "single_drain");
      step(4'b0000, 1'b1, "single_idle");
   endtask

   task automatic test_contention();
      sel = 1'b0; do_reset();
      for (int c = 0; c < 6; c++) begin
         rand_lanes();
         step(4'b0011, 1'b1, "contention");
         tests++;
         if (o_g !== 2'(c % 2)) begin
            fails++;
            $display("FAIL contention_order c=%0d: got %0d want %0d", c, o_g, c % 2);
         end
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0; do_reset();
      rand_lanes();
      step(4'b0010, 1'b1, "bp_load_cp1");
      rand_lanes();
      for (int c = 0; c < 3; c++) step(4'b0011, 1'b0, "bp_hold");
      tests++;
      if (o_g !== 2'd1) begin
         fails++;
         $display("FAIL bp_grant: got %0d want 1", o_g);
      end
      step(4'b0011, 1'b1, "bp_release");
      tests++;
      if (o_g !== 2'd0) begin
         fails++;
         $display("FAIL bp_next: got %0d want 0", o_g);
      end
      step(4'b0000, 1'b1, "bp_drain");
   endtask

   task automatic test_rd_zero();
      sel = 1'b0; do_reset();
      set_lane(1, 4'hA, 32'h1234_5678, 5'd0, 1'b1);
      step(4'b0010, 1'b1, "rd_zero");
      tests++;
      if (o_we !== 1'b0 || o_xv !== 1'b1 || o_id !== 4'hA) begin
         fails++;
         $display("FAIL rd_zero_const: got we=%b v=%b id=%h want we=0 v=1 id=a", o_we, o_xv, o_id);
      end
   endtask

   task automatic test_wrap();
      sel = 1'b1; do_reset();
      rand_lanes();
      step(4'b0100, 1'b1, "wrap_cp2");
      step(4'b0101, 1'b1, "wrap_0101");
      tests++;
      if (o_g !== 2'd0) begin
         fails++;
         $display("FAIL wrap_first: got %0d want 0", o_g);
      end
      step(4'b0100, 1'b1, "wrap_0100");
      tests++;
      if (o_g !== 2'd2) begin
         fails++;
         $display("FAIL wrap_second: got %0d want 2", o_g);
      end
   endtask

   task automatic test_random();
      sel = 1'b1; do_reset();
      for (int c = 0; c < 60; c++) begin
         rand_lanes();
         step(4'($urandom), 1'($urandom_range(0, 3) != 0), "random4");
      end
      sel = 1'b0; do_reset();
      for (int c = 0; c < 30; c++) begin
         rand_lanes();
         step(4'($urandom), 1'($urandom), "random2");
      end
   endtask

   task automatic test_async_reset();
      sel = 1'b0; do_reset();
      rand_lanes();
      step(4'b0001, 1'b0, "ar_load");
      step(4'b0001, 1'b0, "ar_hold");
      #2;
      rst_n = 1'b0;
      #1;
      sample();
      tests++;
      if (o_xv !== 1'b0 || o_rdy !== 4'b0 || o_data !== 32'h0 || o_g !== 2'b0) begin
         fails++;
         $display("FAIL async_reset: got v=%b rdy=%b d=%h g=%0d want 0", o_xv, o_rdy, o_data, o_g);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_ptr = 0;
      step(4'b0000, 1'b1, "ar_after");
      step(4'b0000, 1'b0, "ar_after2");
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_rd_zero();
      test_wrap();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
